// File: rtl/evt_stream_packetizer.sv
// Event-word buffer and serializer: encoded events go into a synchronous FIFO, and each event
// leaves as BEATS fixed-width beats on a valid/ready link, most significant beat first.
module evt_stream_packetizer #(
    parameter int unsigned EVT_W = 24,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned BEATS = (EVT_W + OUT_W - 1) / OUT_W,
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [EVT_W-1:0] evt_data_i,
    input  logic             evt_valid_i,
    output logic [OUT_W-1:0] tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic             tx_last_o,
    output logic [LVL_W-1:0] fifo_level_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned SER_W = BEATS * OUT_W;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    logic [EVT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [CNT_W-1:0] drop_cnt_q;
    logic             overflow_q;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SER_W-1:0] sr_q, sr_d;
    logic [SER_W-1:0] head;

    logic push, pop, drop, last_beat;

    assign full_o       = (level_q == LVL_W'(DEPTH));
    assign empty_o      = (level_q == '0);
    assign fifo_level_o = level_q;
    assign overflow_o   = overflow_q;
    assign drop_cnt_o   = drop_cnt_q;

    // A full FIFO rejects the write even if the serializer pops in the same cycle.
    assign push = evt_valid_i && !full_o;
    assign drop = evt_valid_i && full_o;

    always_comb begin
        head            = '0;
        head[EVT_W-1:0] = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= evt_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop) begin
                level_q <= level_q + LVL_W'(1);
            end else if (pop && !push) begin
                level_q <= level_q - LVL_W'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    assign last_beat = (idx_q == IDX_W'(BEATS - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty_o) begin
                    pop     = 1'b1;
                    sr_d    = head;
                    idx_d   = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (tx_ready_i) begin
                    if (!last_beat) begin
                        idx_d = idx_q + IDX_W'(1);
                        sr_d  = sr_q << OUT_W;
                    end else if (!empty_o) begin
                        // Back-to-back: reload on the final handshake, no idle bubble.
                        pop   = 1'b1;
                        sr_d  = head;
                        idx_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            sr_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
        end
    end

    // Outputs come from registered state only, so tx_ready_i has no path to them.
    assign tx_valid_o = (state_q == StSend);
    assign tx_last_o  = tx_valid_o && last_beat;
    assign tx_data_o  = tx_valid_o ? sr_q[SER_W-1 -: OUT_W] : '0;

endmodule

// File: tb/tb_evt_stream_packetizer.sv
// Directed bench for evt_stream_packetizer: stimulus queues expected beats, a negedge monitor
// pops and compares every accepted beat.
module tb_evt_stream_packetizer;

    logic        clk;
    logic        reset;
    logic [23:0] evt_data;
    logic        evt_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic [2:0]  fifo_level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [1:0]  drop_cnt;

    int n_checks = 0;
    int n_fails  = 0;
    logic [8:0] exp_q [$];

    evt_stream_packetizer #(
        .EVT_W(24),
        .OUT_W(8),
        .DEPTH(4),
        .CNT_W(2)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .evt_data_i  (evt_data),
        .evt_valid_i (evt_valid),
        .tx_data_o   (tx_data),
        .tx_valid_o  (tx_valid),
        .tx_ready_i  (tx_ready),
        .tx_last_o   (tx_last),
        .fifo_level_o(fifo_level),
        .full_o      (full),
        .empty_o     (empty),
        .overflow_o  (overflow),
        .drop_cnt_o  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [23:0] d);
        exp_q.push_back({1'b0, d[23:16]});
        exp_q.push_back({1'b0, d[15:8]});
        exp_q.push_back({1'b1, d[7:0]});
    endtask

    task automatic send_evt(input logic [23:0] d, input bit accept);
        evt_data  = d;
        evt_valid = 1'b1;
        if (accept) push_exp(d);
        tick();
        evt_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (exp_q.size() == 0 && !tx_valid) begin
                done = 1'b1;
                break;
            end
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    // Scoreboard monitor: every handshake must match the head of the expected-beat queue.
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {23'd0, tx_last, tx_data}, 32'h1ff);
            end else begin
                check("beat", {23'd0, tx_last, tx_data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bubbles;
        int unstable;
        reset     = 1'b1;
        evt_valid = 1'b0;
        evt_data  = '0;
        tx_ready  = 1'b0;
        tick();
        tick();
        check("rst_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_last",  {31'd0, tx_last},  32'd0);
        check("rst_data",  {24'd0, tx_data},  32'd0);
        check("rst_level", {29'd0, fifo_level}, 32'd0);
        check("rst_full",  {31'd0, full},     32'd0);
        check("rst_empty", {31'd0, empty},    32'd1);
        check("rst_ovf",   {31'd0, overflow}, 32'd0);
        check("rst_drop",  {30'd0, drop_cnt}, 32'd0);
        reset    = 1'b0;
        tx_ready = 1'b1;
        tick();

        // Single event: one cycle in the FIFO, then three beats.
        send_evt(24'hA5C3F1, 1'b1);
        check("lat_valid_low", {31'd0, tx_valid}, 32'd0);
        check("lat_level", {29'd0, fifo_level}, 32'd1);
        tick();
        check("lat_valid_high", {31'd0, tx_valid}, 32'd1);
        check("lat_first_beat", {24'd0, tx_data}, 32'hA5);
        drain("drain_single", 20);
        check("single_empty", {31'd0, empty}, 32'd1);

        // Two consecutive events must stream as six contiguous beats.
        send_evt(24'h123456, 1'b1);
        send_evt(24'hABCDEF, 1'b1);
        bubbles = 0;
        for (int i = 0; i < 6; i++) begin
            if (!tx_valid) bubbles++;
            tick();
        end
        check("no_bubble", bubbles, 0);
        drain("drain_pair", 20);

        // Backpressure on the middle beat.
        send_evt(24'h0F0E0D, 1'b1);
        tick();
        tick();
        tx_ready = 1'b0;
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            if (!tx_valid || tx_data !== 8'h0E || tx_last) unstable++;
            tick();
        end
        check("bp_hold", unstable, 0);
        tx_ready = 1'b1;
        drain("drain_bp", 20);

        // Overflow: serializer + 4 FIFO words, sixth event dropped.
        tx_ready = 1'b0;
        send_evt(24'h010203, 1'b1);
        send_evt(24'h040506, 1'b1);
        send_evt(24'h070809, 1'b1);
        send_evt(24'h0A0B0C, 1'b1);
        send_evt(24'h0D0E0F, 1'b1);
        send_evt(24'h101112, 1'b0);
        check("ovf_full",  {31'd0, full},       32'd1);
        check("ovf_level", {29'd0, fifo_level}, 32'd4);
        check("ovf_drop",  {30'd0, drop_cnt},   32'd1);
        check("ovf_flag",  {31'd0, overflow},   32'd1);
        check("ovf_head",  {24'd0, tx_data},    32'h01);

        // Saturating drop counter.
        for (int i = 0; i < 5; i++) send_evt(24'hEEEEEE, 1'b0);
        check("sat_drop", {30'd0, drop_cnt}, 32'd3);
        check("sat_ovf",  {31'd0, overflow}, 32'd1);
        tx_ready = 1'b1;
        drain("drain_ovf", 100);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Reset in the middle of a packet with three words queued.
        tx_ready = 1'b0;
        send_evt(24'h212223, 1'b1);
        send_evt(24'h313233, 1'b1);
        send_evt(24'h414243, 1'b1);
        send_evt(24'h515253, 1'b1);
        check("pre_rst_level", {29'd0, fifo_level}, 32'd3);
        tx_ready = 1'b1;
        tick();
        check("pre_rst_beat2", {24'd0, tx_data}, 32'h22);
        reset    = 1'b1;
        tx_ready = 1'b0;
        exp_q.delete();
        tick();
        check("mid_rst_valid", {31'd0, tx_valid},   32'd0);
        check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
        check("mid_rst_empty", {31'd0, empty},      32'd1);
        check("mid_rst_drop",  {30'd0, drop_cnt},   32'd0);
        reset    = 1'b0;
        tx_ready = 1'b1;
        tick();
        send_evt(24'h5A6B7C, 1'b1);
        drain("drain_post_rst", 20);

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
